seq_shift_add_multiplier: RTL and testbench

// Parametrised iterative multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial-product bit per clock (radix-2 shift-add).

---
 rtl/seq_shift_add_multiplier_if.sv | 15 +
 rtl/seq_shift_add_multiplier.sv | 68 ++++++
 tb/tb_seq_shift_add_multiplier.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: operand/result handshake bundle for the shift-add multiplier.
// Master drives operands and result acceptance; slave is the multiplier.
interface seq_shift_add_multiplier_if #(parameter int WIDTH = 8) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] y;
    logic               busy;

    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, y, busy);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, y, busy);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: radix-2 shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand, mplier, acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] y_q;
    logic [WIDTH:0]     sum;
    logic               last;

    assign last  = cnt == CNT_W'(WIDTH - 1);
    assign bus.y = y_q;

`ifdef SEQ_MULT_SIGNED_EN
    // Final multiplier bit carries negative weight, so it subtracts.
    logic [WIDTH:0] addend;
    always_comb begin
        addend = {mcand[WIDTH-1], mcand};
        sum    = {acc[WIDTH-1], acc} + (mplier[0] ? (last ? -addend : addend) : '0);
    end
`else
    always_comb sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (bus.in_valid ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) :
                   (state == DONE) ? (bus.out_ready ? IDLE : DONE) : IDLE;

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy      = state == RUN || state == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            y_q    <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last) y_q <= {sum, mplier[WIDTH-1:1]};
        end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench for the shift-add multiplier at WIDTH=8 and WIDTH=3.
// Honours SEQ_MULT_SIGNED_EN in its reference model.
module tb_seq_shift_add_multiplier;
    localparam int W = 8;

    logic clk = 0, rst = 1, rst3 = 1;
    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.WIDTH(W)) m ();
    seq_shift_add_multiplier_if #(.WIDTH(3)) m3 ();

    seq_shift_add_multiplier #(.WIDTH(W)) dut  (.clk(clk), .rst(rst),  .bus(m.slave));
    seq_shift_add_multiplier #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst3), .bus(m3.slave));

    int n_chk = 0, n_fail = 0, cyc = 0, or_mode = 0;
    bit done3 = 0;
    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    logic [5:0]     exp3_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an unexpected event, required none (cycle %0d)", name, cyc);
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z);
        longint p;
`ifdef SEQ_MULT_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(z));
`else
        p = longint'(x) * longint'(z);
`endif
        return p[2*W-1:0];
    endfunction

    function automatic logic [5:0] model3(input logic [2:0] x, input logic [2:0] z);
        longint p;
`ifdef SEQ_MULT_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(z));
`else
        p = longint'(x) * longint'(z);
`endif
        return p[5:0];
    endfunction

    // out_ready policy: 0 always ready, 1 random, 2 held low
    initial forever begin
        @(posedge clk);
        #1;
        m.out_ready = or_mode == 2 ? 1'b0 : or_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] z);
        int n = 0;
        @(posedge clk);
        #1;
        m.in_valid = 1;
        m.a = x;
        m.b = z;
        @(negedge clk);
        while (!m.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", m.in_ready, 1);
        if (m.in_ready) begin
            exp_q.push_back(model(x, z));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        m.in_valid = 0;
        m.a = W'($urandom);
        m.b = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    initial begin
        logic ov_prev = 0, hs_prev = 0, hs;
        logic [2*W-1:0] y_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev = 0;
                hs_prev = 0;
            end else begin
                chk("ready_vs_busy", m.in_ready, !m.busy);
                if (hs_prev) chk("ready_after_take", m.in_ready, 1);
                if (m.out_valid && !ov_prev) begin
                    if (acc_q.size() == 0) fail_now("valid_without_accept");
                    else chk("latency", 64'(cyc - acc_q.pop_front()), W);
                end
                if (m.out_valid && ov_prev && !hs_prev) chk("y_held", m.y, y_prev);
                hs = m.out_valid && m.out_ready;
                if (hs) begin
                    if (exp_q.size() == 0) fail_now("unexpected_result");
                    else chk("y", m.y, exp_q.pop_front());
                end
                ov_prev = m.out_valid;
                y_prev  = m.y;
                hs_prev = hs;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst3 && m3.out_valid) begin
            if (exp3_q.size() == 0) fail_now("unexpected_result3");
            else chk("y3", m3.y, exp3_q.pop_front());
        end
    end

    initial begin
        int n;
        m3.in_valid = 0;
        m3.out_ready = 1;
        m3.a = 0;
        m3.b = 0;
        while (rst3) @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                @(posedge clk);
                #1;
                m3.in_valid = 1;
                m3.a = 3'(i);
                m3.b = 3'(j);
                @(negedge clk);
                n = 0;
                while (!m3.in_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("accept3", m3.in_ready, 1);
                if (m3.in_ready) exp3_q.push_back(model3(3'(i), 3'(j)));
                @(posedge clk);
                #1;
                m3.in_valid = 0;
            end
        n = 0;
        while ((exp3_q.size() != 0 || m3.busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain3", 64'(exp3_q.size()), 0);
        done3 = 1;
    end

    initial begin
        int n = 0;
        m.in_valid = 0;
        m.a = 0;
        m.b = 0;
        m.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", m.in_ready, 1);
        chk("rst_out_valid", m.out_valid, 0);
        chk("rst_busy", m.busy, 0);
        chk("rst_y", m.y, 0);
        rst = 0;
        rst3 = 0;
        // full-scale operands, then zero and one multiplicands back to back
        issue(8'd255, 8'd255);
        drain();
        issue(8'd0, 8'd173);
        issue(8'd1, 8'd173);
        drain();
        // backpressure with ignored operand pulses while the result waits
        or_mode = 2;
        issue(8'd12, 8'd11);
        repeat (W + 2) @(posedge clk);
        #1;
        m.in_valid = 1;
        m.a = 8'd99;
        m.b = 8'd77;
        repeat (10) @(posedge clk);
        #1;
        m.in_valid = 0;
        @(negedge clk);
        chk("bp_out_valid", m.out_valid, 1);
        chk("bp_busy", m.busy, 1);
        or_mode = 0;
        drain();
        // reset in the middle of a run discards the product
        issue(8'd200, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrst_out_valid", m.out_valid, 0);
        chk("midrst_busy", m.busy, 0);
        chk("midrst_y", m.y, 0);
        chk("midrst_in_ready", m.in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        issue(8'd5, 8'd6);
        drain();
        // signed extremes
        issue(8'h80, 8'h80);
        issue(8'hFF, 8'h01);
        issue(8'h80, 8'h7F);
        issue(8'h7F, 8'h7F);
        drain();
        or_mode = 1;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(W'($urandom), W'($urandom));
        end
        drain();
        while (!done3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done3", done3, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
